spi_master_xfer_ctrl: RTL and testbench

SPI master transfer controller that shares one SPI bus (sclk, per-slave active-low cs, mosi0-3, miso0-3) between NO_OF_REQ requesters. Requesters are granted round-robin. Each granted request sequences one fixed-length word transfer to one selected slave in standard (1-bit) or quad (4-bit) mode, using programmable clock divider, CPOL and CPHA. The block sits between the bus-side register logic and the SPI pins. The RX word returns on a single response port tagged with the requester ID.

---
 rtl/spi_master_xfer_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_spi_master_xfer_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_xfer_ctrl.sv
// SPI master transfer controller: round-robin arbitration between requesters,
// one fixed-length word per grant, standard or quad lanes, programmable
// divider / CPOL / CPHA, response returned tagged with the requester ID.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | bus parked, cs all high, sclk at CPOL, arbitrate and accept
// SETUP | selected cs low for H cycles, first bits on mosi when CPHA=0
// SHIFT | sclk toggles every H cycles, 2B edges, sample/shift per CPHA
// HOLD  | sclk parked at idle level, cs still low for H cycles
// DONE  | cs released, rsp_valid pulses, back to IDLE
module spi_master_xfer_ctrl #(
    parameter int NO_OF_REQ    = 2,
    parameter int NO_OF_SLAVES = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int DIV_WIDTH    = 8,
    localparam int CSW         = $clog2(NO_OF_SLAVES),
    localparam int IDW         = $clog2(NO_OF_REQ)
) (
    input  logic                          pclk,
    input  logic                          areset,
    input  logic [NO_OF_REQ-1:0]          req_valid,
    output logic [NO_OF_REQ-1:0]          req_ready,
    input  logic [NO_OF_REQ*CSW-1:0]      req_cs_sel,
    input  logic [NO_OF_REQ-1:0]          req_quad,
    input  logic [NO_OF_REQ*DATA_WIDTH-1:0] req_tx_data,
    input  logic [DIV_WIDTH-1:0]          cfg_div,
    input  logic                          cfg_cpol,
    input  logic                          cfg_cpha,
    output logic                          rsp_valid,
    output logic [IDW-1:0]                rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_rx_data,
    output logic                          sclk,
    output logic [NO_OF_SLAVES-1:0]       cs,
    output logic                          mosi0,
    output logic                          mosi1,
    output logic                          mosi2,
    output logic                          mosi3,
    input  logic                          miso0,
    input  logic                          miso1,
    input  logic                          miso2,
    input  logic                          miso3
);

    localparam int ECW = $clog2(2 * DATA_WIDTH) + 1;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    state_t                  state_q, state_d;
    logic [IDW-1:0]          last_q, last_d;
    logic [IDW-1:0]          owner_q, owner_d;
    logic [CSW-1:0]          sel_q, sel_d;
    logic                    quad_q, quad_d;
    logic                    cpol_q, cpol_d;
    logic                    cpha_q, cpha_d;
    logic [DIV_WIDTH-1:0]    div_q, div_d;
    logic [DIV_WIDTH:0]      timer_q, timer_d;
    logic [ECW-1:0]          edge_cnt_q, edge_cnt_d;
    logic [DATA_WIDTH-1:0]   tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-1:0]   rx_sr_q, rx_sr_d;
    logic                    sclk_q, sclk_d;
    logic [NO_OF_SLAVES-1:0] cs_q, cs_d;
    logic [3:0]              mosi_q, mosi_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]          rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0]   rsp_rx_data_q, rsp_rx_data_d;

    logic                    gnt_found;
    logic [IDW-1:0]          gnt_idx;
    logic [IDW:0]            rr_cand;
    logic [DATA_WIDTH-1:0]   tx_in;
    logic [CSW-1:0]          sel_in;
    logic                    quad_in;
    logic [DIV_WIDTH:0]      h_val;
    logic [DIV_WIDTH:0]      h_in;
    logic [ECW-1:0]          last_edge;
    logic                    sample_edge;

    function automatic logic [3:0] lead_bits(input logic [DATA_WIDTH-1:0] d, input logic q);
        return q ? d[DATA_WIDTH-1 -: 4] : {3'b000, d[DATA_WIDTH-1]};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] drop_lead(input logic [DATA_WIDTH-1:0] d, input logic q);
        return q ? (d << 4) : (d << 1);
    endfunction

    // Round-robin search starting just after the last granted requester
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        rr_cand   = '0;
        for (int i = 1; i <= NO_OF_REQ; i++) begin
            rr_cand = {1'b0, last_q} + (IDW+1)'(i);
            if (rr_cand >= (IDW+1)'(NO_OF_REQ)) begin
                rr_cand = rr_cand - (IDW+1)'(NO_OF_REQ);
            end
            if (!gnt_found && req_valid[rr_cand[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = rr_cand[IDW-1:0];
            end
        end
    end

    // Grant strobe only while parked, never while reset is being applied
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && !areset && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        owner_d       = owner_q;
        sel_d         = sel_q;
        quad_d        = quad_q;
        cpol_d        = cpol_q;
        cpha_d        = cpha_q;
        div_d         = div_q;
        timer_d       = timer_q;
        edge_cnt_d    = edge_cnt_q;
        tx_sr_d       = tx_sr_q;
        rx_sr_d       = rx_sr_q;
        sclk_d        = sclk_q;
        cs_d          = cs_q;
        mosi_d        = mosi_q;
        rsp_valid_d   = 1'b0;
        rsp_id_d      = rsp_id_q;
        rsp_rx_data_d = rsp_rx_data_q;

        tx_in       = req_tx_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        sel_in      = req_cs_sel[gnt_idx*CSW +: CSW];
        quad_in     = req_quad[gnt_idx];
        h_val       = {1'b0, div_q} + 1'b1;
        h_in        = {1'b0, cfg_div} + 1'b1;
        last_edge   = quad_q ? ECW'(2 * DATA_WIDTH / 4 - 1) : ECW'(2 * DATA_WIDTH - 1);
        // even edge index = leading edge; CPHA=0 samples leading, CPHA=1 trailing
        sample_edge = (edge_cnt_q[0] == cpha_q);

        unique case (state_q)
            IDLE: begin
                sclk_d = cfg_cpol;
                cs_d   = '1;
                mosi_d = 4'h0;
                if (gnt_found) begin
                    state_d    = SETUP;
                    last_d     = gnt_idx;
                    owner_d    = gnt_idx;
                    sel_d      = sel_in;
                    quad_d     = quad_in;
                    cpol_d     = cfg_cpol;
                    cpha_d     = cfg_cpha;
                    div_d      = cfg_div;
                    timer_d    = h_in - 1'b1;
                    edge_cnt_d = '0;
                    rx_sr_d    = '0;
                    for (int s = 0; s < NO_OF_SLAVES; s++) begin
                        cs_d[s] = (CSW'(s) != sel_in);
                    end
                    if (!cfg_cpha) begin
                        mosi_d  = lead_bits(tx_in, quad_in);
                        tx_sr_d = drop_lead(tx_in, quad_in);
                    end else begin
                        tx_sr_d = tx_in;
                    end
                end
            end
            SETUP, SHIFT: begin
                if (timer_q == '0) begin
                    timer_d    = h_val - 1'b1;
                    sclk_d     = ~sclk_q;
                    edge_cnt_d = edge_cnt_q + 1'b1;
                    if (sample_edge) begin
                        rx_sr_d = quad_q ? {rx_sr_q[DATA_WIDTH-5:0], miso3, miso2, miso1, miso0}
                                         : {rx_sr_q[DATA_WIDTH-2:0], miso0};
                    end else begin
                        mosi_d  = lead_bits(tx_sr_q, quad_q);
                        tx_sr_d = drop_lead(tx_sr_q, quad_q);
                    end
                    if (state_q == SETUP) begin
                        state_d = SHIFT;
                    end else if (edge_cnt_q == last_edge) begin
                        state_d = HOLD;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            HOLD: begin
                if (timer_q == '0) begin
                    state_d       = DONE;
                    cs_d          = '1;
                    rsp_valid_d   = 1'b1;
                    rsp_id_d      = owner_q;
                    rsp_rx_data_d = rx_sr_q;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cs_d    = '1;
                sclk_d  = cpol_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge pclk) begin
        if (areset) begin
            state_q       <= IDLE;
            last_q        <= IDW'(NO_OF_REQ - 1);
            owner_q       <= '0;
            sel_q         <= '0;
            quad_q        <= 1'b0;
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            div_q         <= '0;
            timer_q       <= '0;
            edge_cnt_q    <= '0;
            tx_sr_q       <= '0;
            rx_sr_q       <= '0;
            sclk_q        <= 1'b0;
            cs_q          <= '1;
            mosi_q        <= 4'h0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_rx_data_q <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            owner_q       <= owner_d;
            sel_q         <= sel_d;
            quad_q        <= quad_d;
            cpol_q        <= cpol_d;
            cpha_q        <= cpha_d;
            div_q         <= div_d;
            timer_q       <= timer_d;
            edge_cnt_q    <= edge_cnt_d;
            tx_sr_q       <= tx_sr_d;
            rx_sr_q       <= rx_sr_d;
            sclk_q        <= sclk_d;
            cs_q          <= cs_d;
            mosi_q        <= mosi_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_rx_data_q <= rsp_rx_data_d;
        end
    end

    assign sclk        = sclk_q;
    assign cs          = cs_q;
    assign mosi0       = mosi_q[0];
    assign mosi1       = mosi_q[1];
    assign mosi2       = mosi_q[2];
    assign mosi3       = mosi_q[3];
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_rx_data = rsp_rx_data_q;

endmodule

// File: tb/tb_spi_master_xfer_ctrl.sv
// Directed bench for spi_master_xfer_ctrl with loopback and a quad slave model.
module tb_spi_master_xfer_ctrl;

    logic        pclk = 1'b0;
    logic        areset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_cs_sel;
    logic [1:0]  req_quad;
    logic [63:0] req_tx_data;
    logic [7:0]  cfg_div;
    logic        cfg_cpol;
    logic        cfg_cpha;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_rx_data;
    logic        sclk;
    logic [3:0]  cs;
    logic        mosi0, mosi1, mosi2, mosi3;
    logic        miso0, miso1, miso2, miso3;

    logic        loop_mode;
    logic        slv_en;
    logic [31:0] slv_word;
    int          slv_base;
    logic [3:0]  slv_nib;

    int rise_cnt = 0;
    int fall_cnt = 0;
    int rsp_cnt  = 0;
    int rdy_viol = 0;
    int n_checks = 0;
    int n_fail   = 0;

    spi_master_xfer_ctrl dut (
        .pclk(pclk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cs_sel(req_cs_sel),
        .req_quad(req_quad), .req_tx_data(req_tx_data),
        .cfg_div(cfg_div), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rx_data(rsp_rx_data),
        .sclk(sclk), .cs(cs),
        .mosi0(mosi0), .mosi1(mosi1), .mosi2(mosi2), .mosi3(mosi3),
        .miso0(miso0), .miso1(miso1), .miso2(miso2), .miso3(miso3)
    );

    always #5 pclk = ~pclk;

    // slave presents the next nibble after every falling (leading, CPOL=1) edge
    assign slv_nib = slv_en ? 4'(slv_word >> (4 * (8 - (fall_cnt - slv_base)))) : 4'h0;
    assign miso0 = loop_mode ? mosi0 : slv_nib[0];
    assign miso1 = loop_mode ? mosi1 : slv_nib[1];
    assign miso2 = loop_mode ? mosi2 : slv_nib[2];
    assign miso3 = loop_mode ? mosi3 : slv_nib[3];

    always @(posedge sclk) rise_cnt <= rise_cnt + 1;
    always @(negedge sclk) fall_cnt <= fall_cnt + 1;
    always @(negedge pclk) if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    always @(negedge pclk)
        if (!areset && req_ready != 2'b00 && (cs != 4'hF || rsp_valid || req_ready == 2'b11))
            rdy_viol <= rdy_viol + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // returns #1 after the accepting edge, i.e. in cycle 1
    task automatic start_xfer(input logic [1:0] mask, input int exp_id, input string tag);
        int n;
        @(negedge pclk);
        req_valid = mask;
        n = 0;
        #1;
        while (req_ready == 2'b00 && n < 300) begin
            @(negedge pclk);
            #1;
            n++;
        end
        chk({tag, "_grant"}, 32'(req_ready), 32'(1 << exp_id));
        chk({tag, "_idle_cs"}, 32'(cs), 32'hF);
        @(posedge pclk);
        #1;
    endtask

    task automatic wait_rsp(input int start_cyc, input int budget, output int cyc);
        cyc = start_cyc;
        while (1) begin
            @(negedge pclk);
            if (rsp_valid || cyc >= budget) break;
            @(posedge pclk);
            cyc++;
        end
        chk("rsp_seen", 32'(rsp_valid), 32'h1);
    endtask

    initial begin
        int cyc, r0, f0, e0, p0, exp_id;
        areset = 1'b1; req_valid = 2'b00; req_cs_sel = 4'h0; req_quad = 2'b00;
        req_tx_data = '0; cfg_div = 8'd1; cfg_cpol = 1'b0; cfg_cpha = 1'b0;
        loop_mode = 1'b1; slv_en = 1'b0; slv_word = '0; slv_base = 0;

        // reset values
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        req_valid = 2'b01;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rsp_rx", rsp_rx_data, 32'h0);
        chk("rst_sclk", 32'(sclk), 32'h0);
        chk("rst_cs", 32'(cs), 32'hF);
        chk("rst_mosi", 32'({mosi3, mosi2, mosi1, mosi0}), 32'h0);
        req_valid = 2'b00;
        @(negedge pclk);
        areset = 1'b0;

        // mode 0, standard, H=2, loopback
        req_cs_sel[1:0] = 2'd2; req_quad[0] = 1'b0; req_tx_data[31:0] = 32'hA5A50F0F;
        repeat (3) @(negedge pclk);
        r0 = rise_cnt;
        start_xfer(2'b01, 0, "t1");
        req_valid = 2'b00;
        chk("t1_cs_sel", 32'(cs), 32'hB);
        wait_rsp(1, 200, cyc);
        chk("t1_rsp_cycle", 32'(cyc), 32'd131);
        chk("t1_rsp_id", 32'(rsp_id), 32'h0);
        chk("t1_rx", rsp_rx_data, 32'hA5A50F0F);
        chk("t1_rises", 32'(rise_cnt - r0), 32'd32);
        repeat (5) @(negedge pclk);
        chk("t1_rx_stable", rsp_rx_data, 32'hA5A50F0F);

        // CPOL=1 CPHA=1, quad, H=1, slave returns 0x87654321
        cfg_cpol = 1'b1; cfg_cpha = 1'b1; cfg_div = 8'd0;
        req_cs_sel[3:2] = 2'd1; req_quad[1] = 1'b1; req_tx_data[63:32] = 32'h12345678;
        loop_mode = 1'b0; slv_word = 32'h87654321;
        repeat (3) @(negedge pclk);
        chk("t2_idle_sclk", 32'(sclk), 32'h1);
        slv_base = fall_cnt;
        f0 = fall_cnt;
        slv_en = 1'b1;
        start_xfer(2'b10, 1, "t2");
        req_valid = 2'b00;
        @(posedge pclk);
        #1;
        chk("t2_first_nibble", 32'({mosi3, mosi2, mosi1, mosi0}), 32'h1);
        wait_rsp(2, 100, cyc);
        chk("t2_rsp_cycle", 32'(cyc), 32'd18);
        chk("t2_rsp_id", 32'(rsp_id), 32'h1);
        chk("t2_rx", rsp_rx_data, 32'h87654321);
        chk("t2_leading_edges", 32'(fall_cnt - f0), 32'd8);
        @(posedge pclk);
        #1;
        chk("t2_sclk_idle", 32'(sclk), 32'h1);
        slv_en = 1'b0;

        // round robin with both requesters held valid, quad loopback
        cfg_cpol = 1'b0; cfg_cpha = 1'b0; loop_mode = 1'b1; req_quad = 2'b11;
        req_cs_sel = {2'd3, 2'd0}; req_tx_data = {32'h2468ACE0, 32'h13579BDF};
        repeat (3) @(negedge pclk);
        for (int k = 0; k < 4; k++) begin
            exp_id = k % 2;
            start_xfer(2'b11, exp_id, $sformatf("t3_%0d", k));
            if (k == 3) req_valid = 2'b00;
            wait_rsp(1, 100, cyc);
            chk($sformatf("t3_%0d_id", k), 32'(rsp_id), 32'(exp_id));
            chk($sformatf("t3_%0d_rx", k), rsp_rx_data, (exp_id == 1) ? 32'h2468ACE0 : 32'h13579BDF);
            chk($sformatf("t3_%0d_cycle", k), 32'(cyc), 32'd18);
        end

        // reset at the 10th sclk edge of a standard transfer
        cfg_div = 8'd1; req_quad = 2'b00; req_cs_sel[1:0] = 2'd2;
        req_tx_data[31:0] = 32'hC3C35A5A;
        repeat (3) @(negedge pclk);
        e0 = rise_cnt + fall_cnt;
        start_xfer(2'b01, 0, "t4");
        req_valid = 2'b00;
        for (int n = 0; n < 100; n++) begin
            @(negedge pclk);
            if (rise_cnt + fall_cnt - e0 >= 10) break;
        end
        chk("t4_edges_before_rst", 32'(rise_cnt + fall_cnt - e0), 32'd10);
        areset = 1'b1;
        @(posedge pclk);
        #1;
        chk("t4_rst_cs", 32'(cs), 32'hF);
        chk("t4_rst_sclk", 32'(sclk), 32'h0);
        chk("t4_rst_mosi", 32'({mosi3, mosi2, mosi1, mosi0}), 32'h0);
        chk("t4_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        @(negedge pclk);
        areset = 1'b0;
        p0 = rsp_cnt;
        repeat (150) @(negedge pclk);
        chk("t4_no_rsp", 32'(rsp_cnt - p0), 32'h0);
        start_xfer(2'b11, 0, "t4_after");
        req_valid = 2'b00;
        wait_rsp(1, 200, cyc);
        chk("t4_after_cycle", 32'(cyc), 32'd131);
        chk("t4_after_id", 32'(rsp_id), 32'h0);
        chk("t4_after_rx", rsp_rx_data, 32'hC3C35A5A);

        // divider change mid-transfer only affects the next transfer
        req_tx_data = {32'hFEDCBA98, 32'h0F1E2D3C}; req_cs_sel = 4'h0;
        repeat (3) @(negedge pclk);
        r0 = rise_cnt;
        start_xfer(2'b01, 0, "t5a");
        req_valid = 2'b00;
        repeat (20) @(posedge pclk);
        #1;
        cfg_div = 8'd3;
        wait_rsp(21, 200, cyc);
        chk("t5a_cycle", 32'(cyc), 32'd131);
        chk("t5a_rx", rsp_rx_data, 32'h0F1E2D3C);
        chk("t5a_rises", 32'(rise_cnt - r0), 32'd32);
        start_xfer(2'b10, 1, "t5b");
        req_valid = 2'b00;
        wait_rsp(1, 400, cyc);
        chk("t5b_cycle", 32'(cyc), 32'd261);
        chk("t5b_id", 32'(rsp_id), 32'h1);
        chk("t5b_rx", rsp_rx_data, 32'hFEDCBA98);

        // maximum divider, H=256
        cfg_div = 8'hFF; req_tx_data[31:0] = 32'h600DF00D;
        repeat (3) @(negedge pclk);
        start_xfer(2'b01, 0, "t6");
        req_valid = 2'b00;
        wait_rsp(1, 17000, cyc);
        chk("t6_cycle", 32'(cyc), 32'd16641);
        chk("t6_rx", rsp_rx_data, 32'h600DF00D);

        chk("ready_only_in_idle", 32'(rdy_viol), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
